// File: rtl/sr_bank_ctrl.sv
// sr_bank_ctrl: round-robin arbiter and enable sequencer for a shared gated SR latch bank
// Every command drives each bit to S=new/R=~new, so untouched bits are refreshed and S=R=1 never occurs.
module sr_bank_ctrl #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req,
  input  logic [2*WIDTH-1:0] set_mask,
  input  logic [2*WIDTH-1:0] clr_mask,
  output logic [1:0]         gnt,
  output logic [1:0]         done,
  output logic               err,
  output logic               busy,
  output logic [WIDTH-1:0]   lat_s,
  output logic [WIDTH-1:0]   lat_r,
  output logic               lat_en,
  output logic [WIDTH-1:0]   flags
);
  localparam int CW = $clog2(SETTLE + 2);
  typedef enum logic [1:0] {INIT, IDLE, DRIVE, RELEASE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic last_q, last_d, win_q, win_d, err_q, err_d, lat_en_q, lat_en_d;
  logic [1:0] gnt_q, gnt_d, done_q, done_d;
  logic [WIDTH-1:0] new_q, new_d, flags_q, flags_d, lat_s_q, lat_s_d, lat_r_q, lat_r_d;
  logic w;
  logic [WIDTH-1:0] s, c, nxt;
  always_comb begin
    w   = (req == 2'b11) ? ~last_q : req[1];
    s   = w ? set_mask[2*WIDTH-1:WIDTH] : set_mask[WIDTH-1:0];
    c   = w ? clr_mask[2*WIDTH-1:WIDTH] : clr_mask[WIDTH-1:0];
    nxt = (flags_q | (s & ~c)) & ~(c & ~s);
  end
  // INIT: cnt 0 is the reset cycle, 1..SETTLE drive the clear, SETTLE+1 is the low cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    win_d    = win_q;
    new_d    = new_q;
    flags_d  = flags_q;
    gnt_d    = 2'b00;
    done_d   = 2'b00;
    err_d    = 1'b0;
    lat_s_d  = lat_s_q;
    lat_r_d  = lat_r_q;
    lat_en_d = 1'b0;
    case (state_q)
      INIT: begin
        cnt_d    = cnt_q + 1'b1;
        lat_s_d  = '0;
        lat_r_d  = '1;
        lat_en_d = cnt_q < CW'(SETTLE);
        state_d  = (cnt_q == CW'(SETTLE + 1)) ? IDLE : INIT;
      end
      IDLE: if (|req) begin
        state_d  = DRIVE;
        cnt_d    = CW'(1);
        last_d   = w;
        win_d    = w;
        new_d    = nxt;
        gnt_d    = w ? 2'b10 : 2'b01;
        err_d    = |(s & c);
        lat_en_d = 1'b1;
        lat_s_d  = nxt;
        lat_r_d  = ~nxt;
      end
      DRIVE: if (cnt_q == CW'(SETTLE)) begin
        state_d = RELEASE;
        flags_d = new_q;
        done_d  = win_q ? 2'b10 : 2'b01;
      end else begin
        cnt_d    = cnt_q + 1'b1;
        lat_en_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      new_q    <= '0;
      flags_q  <= '0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      err_q    <= 1'b0;
      lat_s_q  <= '0;
      lat_r_q  <= '0;
      lat_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      win_q    <= win_d;
      new_q    <= new_d;
      flags_q  <= flags_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      lat_s_q  <= lat_s_d;
      lat_r_q  <= lat_r_d;
      lat_en_q <= lat_en_d;
    end
  assign gnt    = gnt_q;
  assign done   = done_q;
  assign err    = err_q;
  assign busy   = state_q != IDLE;
  assign lat_s  = lat_s_q;
  assign lat_r  = lat_r_q;
  assign lat_en = lat_en_q;
  assign flags  = flags_q;
endmodule

// File: tb/tb_sr_bank_ctrl.sv
// tb_sr_bank_ctrl: scoreboard bench for sr_bank_ctrl at WIDTH=4, SETTLE=2
module tb_sr_bank_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [7:0] set_mask = '0, clr_mask = '0;
  logic [1:0] gnt, done;
  logic err, busy, lat_en;
  logic [3:0] lat_s, lat_r, flags;
  typedef struct packed {logic [1:0] d; logic [3:0] f;} exp_t;
  exp_t sb[$];
  logic [3:0] m_flags = '0;
  logic m_last = 1'b1;
  int n_chk = 0, n_fail = 0, cyc = 0;

  sr_bank_ctrl #(.WIDTH(4), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .set_mask(set_mask), .clr_mask(clr_mask),
    .gnt(gnt), .done(done), .err(err), .busy(busy),
    .lat_s(lat_s), .lat_r(lat_r), .lat_en(lat_en), .flags(flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (done !== 2'b00) begin
      if (sb.size() == 0) chk("unexpected_done", {30'd0, done}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("done", {30'd0, done}, {30'd0, e.d});
        chk("flags", {28'd0, flags}, {28'd0, e.f});
      end
    end
  end

  task automatic predict(input logic [1:0] r, input logic [7:0] s, input logic [7:0] c,
                         output logic w, output logic e, output logic [3:0] n);
    logic [3:0] ss, cc;
    w  = (r == 2'b11) ? ~m_last : r[1];
    ss = w ? s[7:4] : s[3:0];
    cc = w ? c[7:4] : c[3:0];
    e  = |(ss & cc);
    n  = (m_flags | (ss & ~cc)) & ~(cc & ~ss);
    m_last  = w;
    m_flags = n;
    sb.push_back({w ? 2'b10 : 2'b01, n});
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy !== 1'b0; i++) @(negedge clk);
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic init_seq();
    logic w, e;
    logic [3:0] n;
    req = 2'b11; set_mask = '0; clr_mask = '0;
    m_flags = '0; m_last = 1'b1;
    @(negedge clk);
    chk("rst_flags", {28'd0, flags}, 0);
    chk("rst_lat_en", {31'd0, lat_en}, 0);
    chk("rst_lat_r", {28'd0, lat_r}, 0);
    chk("rst_gnt_done_err", {27'd0, gnt, done, err}, 0);
    chk("rst_busy", {31'd0, busy}, 1);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("init_en", {31'd0, lat_en}, 1);
      chk("init_r", {28'd0, lat_r}, 32'hF);
      chk("init_s", {28'd0, lat_s}, 0);
      chk("init_busy", {31'd0, busy}, 1);
      chk("init_gnt", {30'd0, gnt}, 0);
    end
    @(negedge clk);
    chk("init_low_en", {31'd0, lat_en}, 0);
    chk("init_low_busy", {31'd0, busy}, 1);
    chk("init_low_gnt", {30'd0, gnt}, 0);
    @(negedge clk);
    chk("first_idle_busy", {31'd0, busy}, 0);
    chk("first_idle_gnt", {30'd0, gnt}, 0);
    predict(2'b11, 8'h00, 8'h00, w, e, n);
    @(negedge clk);
    chk("first_gnt", {30'd0, gnt}, 32'd1);
    chk("first_err", {31'd0, err}, 0);
    req = 2'b00;
  endtask

  task automatic issue(input logic [1:0] r, input logic [7:0] s, input logic [7:0] c);
    logic w, e;
    logic [3:0] n, nn;
    wait_idle();
    predict(r, s, c, w, e, n);
    nn = ~n;
    req = r; set_mask = s; clr_mask = c;
    @(negedge clk);
    chk("gnt", {30'd0, gnt}, w ? 32'd2 : 32'd1);
    chk("err", {31'd0, err}, {31'd0, e});
    req = 2'b00;
    for (int k = 0; k < 2; k++) begin
      chk("drv_en", {31'd0, lat_en}, 1);
      chk("drv_s", {28'd0, lat_s}, {28'd0, n});
      chk("drv_r", {28'd0, lat_r}, {28'd0, nn});
      chk("drv_s_and_r", {28'd0, lat_s & lat_r}, 0);
      @(negedge clk);
    end
    chk("rel_en", {31'd0, lat_en}, 0);
    chk("rel_busy", {31'd0, busy}, 1);
  endtask

  initial begin
    logic w, e;
    logic [3:0] n;
    int tprev;
    repeat (2) @(negedge clk);
    init_seq();
    issue(2'b01, 8'h05, 8'h00);
    issue(2'b10, 8'h30, 8'h60);
    issue(2'b01, 8'h0A, 8'h05);
    issue(2'b01, 8'h00, 8'h00);
    wait_idle();
    set_mask = 8'h41; clr_mask = 8'h10;
    req = 2'b11;
    tprev = 0;
    for (int k = 0; k < 4; k++) begin
      predict(2'b11, set_mask, clr_mask, w, e, n);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (gnt !== 2'b00) break;
      end
      chk("rr_gnt", {30'd0, gnt}, w ? 32'd2 : 32'd1);
      if (k > 0) chk("rr_gap", cyc - tprev, 4);
      tprev = cyc;
    end
    req = 2'b00;
    wait_idle();
    req = 2'b01; set_mask = 8'h0F; clr_mask = 8'h00;
    @(negedge clk);
    chk("mid_gnt", {30'd0, gnt}, 1);
    req = 2'b00;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_en", {31'd0, lat_en}, 0);
    chk("mid_flags", {28'd0, flags}, 0);
    chk("mid_gnt_done_err", {27'd0, gnt, done, err}, 0);
    repeat (2) @(negedge clk);
    init_seq();
    wait_idle();
    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sr_bank_ctrl.md
# sr_bank_ctrl

Controller that shares a WIDTH-bit gated SR latch bank (common enable, per-bit S/R) between two requesters. Arbitrates set/clear commands round-robin and sequences the latch enable. Never drives S=R=1, and never lets an untouched bit see S=R=0 while enabled. Keeps a registered shadow of the latch contents. Sits between the requesting logic and the 4-bit SR latch bank.

## Interface
- WIDTH, 4, latch bank width
- SETTLE, 2, cycles lat_en is held high per command (>=1)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  2  per-requester request, level, held until gnt
- set_mask  in  2*WIDTH  bits to set; requester i uses [i*WIDTH +: WIDTH]
- clr_mask  in  2*WIDTH  bits to clear; same packing
- gnt  out  2  one-hot, 1-cycle pulse: command captured
- done  out  2  one-hot, 1-cycle pulse: command applied
- err  out  1  1-cycle pulse with gnt if captured command had set&clr overlap
- busy  out  1  high in any state except IDLE
- lat_s  out  WIDTH  to latch bank S
- lat_r  out  WIDTH  to latch bank R
- lat_en  out  1  to latch bank En
- flags  out  WIDTH  shadow of latch contents

## Operation
- States: INIT, IDLE, DRIVE, RELEASE.
- **Reset (async, any state):**
  - State goes to INIT.
  - Outputs clear: flags=0, gnt=0, done=0, err=0, lat_s=0, lat_r=0, lat_en=0.
  - Round-robin pointer last=1, so requester 0 wins first.
  - An in-flight command is discarded with no done.
- **INIT:**
  - Drives lat_r=all 1, lat_s=0, lat_en=1 for SETTLE cycles, then lat_en=0 for 1 cycle.
  - Then goes to IDLE. req is ignored. busy=1.
- **IDLE:**
  - lat_en=0; lat_s/lat_r hold last values.
  - If any req, the winner is captured on the edge and the state goes to DRIVE.
  - Winner: the sole requester, or if both request, the one not equal to last. last is updated to the winner.
- **Capture:**
  - eff_set = set & ~clr; eff_clr = clr & ~set.
  - new = (flags | eff_set) & ~eff_clr.
  - Overlapping bits leave the flag unchanged; err pulses.
- **DRIVE** (SETTLE cycles):
  - lat_en=1, lat_s=new, lat_r=~new.
  - Untouched bits are therefore refreshed to their current value. S=R=1 never occurs.
- **RELEASE** (1 cycle):
  - lat_en=0; lat_s/lat_r hold.
  - flags=new is visible this cycle; done[winner]=1.
  - Next state is IDLE.
- A req held high after its gnt is ignored until IDLE. The requester must drop it after gnt, or it is served again.
- Masks of 0 (a no-op command) still complete the full sequence with gnt/done.

## Timing
- Accept edge T0 (end of an IDLE cycle):
  - gnt and err are high in cycle T0+1.
  - DRIVE occupies cycles T0+1 .. T0+SETTLE.
  - RELEASE is cycle T0+SETTLE+1, with done and the flags update.
  - IDLE is reached at T0+SETTLE+2.
- Latency: req to gnt is 1 cycle; gnt to done is SETTLE cycles.
- Throughput: one command per SETTLE+2 cycles. IDLE lasts at least 1 cycle between commands.
- lat_en is never high in IDLE or RELEASE.
- gnt, done and err are registered and high for exactly 1 cycle.
- After rst_n deasserts, INIT lasts SETTLE+1 cycles. The first possible accept is on the edge ending the first IDLE cycle.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- **Reset/INIT (SETTLE=2):**
  - Release rst_n with req=2'b11 held.
  - lat_en=1 with lat_r=4'hF for 2 cycles, then 1 low cycle.
  - No gnt before IDLE; flags=0; busy=1 throughout INIT.
- **Single set:**
  - req0, set=4'b0101, clr=0, flags=0.
  - gnt=01 at T0+1; lat_s=0101, lat_r=1010, lat_en=1 for 2 cycles.
  - done=01 at T0+3; flags=0101.
- **Round-robin:**
  - req=11 held continuously from IDLE.
  - Grants alternate 01, 10, 01, 10, with gnts 4 cycles apart at SETTLE=2.
- **Conflict:**
  - flags=0101; req1 with set=0011, clr=0110.
  - err=1 with gnt=10; flags becomes 0001; lat_s & lat_r=0 in all DRIVE cycles.
- **Mid-operation reset:**
  - Assert rst_n low during the second DRIVE cycle.
  - lat_en=0, flags=0, gnt/done/err=0 immediately (asynchronous); no done pulse.
  - The INIT sequence replays after release.
- **No-op and refresh:**
  - flags=1010; req0 with set=0, clr=0.
  - lat_s=1010, lat_r=0101 during DRIVE; done pulses; flags stays 1010.
